// File: rtl/teclado_antirrebote.sv
// teclado_antirrebote: N_FILAS x N_COLS matrix-keypad scanner.
// Drives one column low at a time, samples the synchronised active-low rows,
// classifies each full sweep (frame) as NONE / SINGLE / MULTI, and debounces
// press and release over DEBOUNCE_SCANS consecutive frames.
// Optional auto-repeat is built only when TECLADO_REPEAT_EN is defined.
module teclado_antirrebote #(
  parameter int N_FILAS        = 4,
  parameter int N_COLS         = 4,
  parameter int SCAN_DIV       = 13_500,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 100,
  parameter int REPEAT_RATE    = 20,
  localparam int CODE_W = (N_FILAS * N_COLS > 1) ? $clog2(N_FILAS * N_COLS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_FILAS-1:0] filas,
  output logic [N_COLS-1:0] columnas,
  output logic [CODE_W-1:0] tecla,
  output logic              tecla_valida,
  output logic              tecla_presionada,
  output logic              tecla_liberada,
  output logic              multi_tecla
);

  localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} state_t;

  logic [N_FILAS-1:0] filas_meta_q, filas_sync_q;
  logic [DIV_W-1:0]   div_q;
  logic [COL_W-1:0]   col_q;
  logic               sample, frame_end;
  logic [1:0]         row_hits, acc_hits_q, tot_hits;
  logic [2:0]         hits_sum;
  int                 row_idx;
  logic [CODE_W-1:0]  code_here, acc_code_q, frame_code;
  logic               frame_none, frame_single, frame_multi;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CODE_W-1:0]  cand_q, cand_d, tecla_q, tecla_d;
  logic               valida_q, valida_d, liberada_q, liberada_d, multi_q, multi_d;

  // Two-flop synchroniser for the asynchronous row lines (idle = released).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filas_meta_q <= '1;
      filas_sync_q <= '1;
    end else begin
      filas_meta_q <= filas;
      filas_sync_q <= filas_meta_q;
    end
  end

  assign sample    = (div_q == DIV_LAST);
  assign frame_end = sample && (col_q == COL_LAST);

  // Column dwell divider and column index; rows are sampled on the last dwell cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      col_q <= '0;
    end else begin
      div_q <= sample ? '0 : div_q + 1'b1;
      if (sample) col_q <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    end
  end

  for (genvar gi = 0; gi < N_COLS; gi++) begin : g_col
    assign columnas[gi] = (col_q != COL_W'(gi));
  end

  // Count pressed rows in the driven column (saturating at 2) and fold into the frame.
  always_comb begin
    row_hits = 2'd0;
    row_idx  = 0;
    for (int r = 0; r < N_FILAS; r++) begin
      if (!filas_sync_q[r]) begin
        row_idx = r;
        if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
      end
    end
    code_here    = CODE_W'(row_idx * N_COLS + int'(col_q));
    hits_sum     = {1'b0, acc_hits_q} + {1'b0, row_hits};
    tot_hits     = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    frame_code   = (acc_hits_q != 2'd0) ? acc_code_q : code_here;
    frame_none   = (tot_hits == 2'd0);
    frame_single = (tot_hits == 2'd1);
    frame_multi  = (tot_hits == 2'd2);
  end

  // Per-frame key accumulator, cleared at each frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hits_q <= 2'd0;
      acc_code_q <= '0;
    end else if (sample) begin
      if (frame_end) begin
        acc_hits_q <= 2'd0;
        acc_code_q <= '0;
      end else begin
        acc_hits_q <= tot_hits;
        if (acc_hits_q == 2'd0) acc_code_q <= code_here;
      end
    end
  end

  assign cnt_inc = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + 1'b1;

`ifdef TECLADO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_next;
  logic             rep_armed_q, rep_armed_d;
`else
  logic unused_repeat;
  assign unused_repeat = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
`endif

  // Debounce FSM: next state, counters and strobes, evaluated at frame ends.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    tecla_d    = tecla_q;
    valida_d   = 1'b0;
    liberada_d = 1'b0;
    multi_d    = multi_q;
`ifdef TECLADO_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_next    = rep_cnt_q + 1'b1;
`endif
    if (frame_end) begin
      multi_d = frame_multi;
      case (state_q)
        IDLE: begin
          if (frame_single) begin
            cand_d = frame_code;
            if (DEBOUNCE_SCANS == 1) begin
              tecla_d  = frame_code;
              valida_d = 1'b1;
              state_d  = PRESSED;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = DEB_PRESS;
            end
          end
        end
        DEB_PRESS: begin
          if (frame_single && (frame_code == cand_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              tecla_d  = cand_q;
              valida_d = 1'b1;
              state_d  = PRESSED;
            end
          end else begin
            state_d = IDLE;
          end
        end
        PRESSED: begin
          if (frame_none) begin
            if (DEBOUNCE_SCANS == 1) begin
              liberada_d = 1'b1;
              state_d    = IDLE;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = DEB_REL;
            end
          end
`ifdef TECLADO_REPEAT_EN
          if (frame_single && (frame_code == tecla_q)) begin
            if (rep_next == (rep_armed_q ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY))) begin
              valida_d    = 1'b1;
              rep_cnt_d   = '0;
              rep_armed_d = 1'b1;
            end else begin
              rep_cnt_d = rep_next;
            end
          end else begin
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
          end
`endif
        end
        DEB_REL: begin
          if (frame_none) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              liberada_d = 1'b1;
              state_d    = IDLE;
            end
          end else begin
            state_d = PRESSED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef TECLADO_REPEAT_EN
    // Repeat timing restarts every time PRESSED is (re)entered.
    if ((state_d == PRESSED) && (state_q != PRESSED)) begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
    end
`endif
  end

  // Debounce FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cand_q     <= '0;
      tecla_q    <= '0;
      valida_q   <= 1'b0;
      liberada_q <= 1'b0;
      multi_q    <= 1'b0;
`ifdef TECLADO_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      tecla_q    <= tecla_d;
      valida_q   <= valida_d;
      liberada_q <= liberada_d;
      multi_q    <= multi_d;
`ifdef TECLADO_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
`endif
    end
  end

  assign tecla            = tecla_q;
  assign tecla_valida     = valida_q;
  assign tecla_liberada   = liberada_q;
  assign multi_tecla      = multi_q;
  assign tecla_presionada = (state_q == PRESSED) || (state_q == DEB_REL);

endmodule

// File: tb/tb_teclado_antirrebote.sv
// Directed bench for teclado_antirrebote: 4x4, SCAN_DIV=4, DEBOUNCE_SCANS=3.
// A key matrix model pulls a row low while its column is driven low.
module tb_teclado_antirrebote;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] filas;
  logic [3:0] columnas;
  logic [3:0] tecla;
  logic       tecla_valida, tecla_presionada, tecla_liberada, multi_tecla;

  logic [3:0][3:0] keys;   // keys[row][col]
  int checks = 0;
  int failures = 0;
  int valida_hi = 0;
  int liberada_hi = 0;
  int base_v, base_l, exp_rep;

  teclado_antirrebote #(
    .N_FILAS(4), .N_COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
    .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .filas(filas), .columnas(columnas),
    .tecla(tecla), .tecla_valida(tecla_valida),
    .tecla_presionada(tecla_presionada), .tecla_liberada(tecla_liberada),
    .multi_tecla(multi_tecla)
  );

  always #5 clk = ~clk;

  // Key matrix model.
  always_comb begin
    filas = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r][c] && !columnas[c]) filas[r] = 1'b0;
  end

  // Count strobe-high cycles.
  always @(negedge clk) begin
    if (tecla_valida) valida_hi++;
    if (tecla_liberada) liberada_hi++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // From a frame-aligned negedge, run n frames (16 cycles each).
  task automatic run_frames(input int n);
    repeat (16 * n) @(negedge clk);
  endtask

  // One frame checking the column sweep order; starts right after reset release.
  task automatic check_sweep(input string tag);
    logic [3:0] exp_col [4];
    exp_col[0] = 4'b1110; exp_col[1] = 4'b1101;
    exp_col[2] = 4'b1011; exp_col[3] = 4'b0111;
    for (int k = 0; k < 16; k++) begin
      if (k % 4 == 0) check_eq($sformatf("%s_col%0d", tag, k / 4), columnas, exp_col[k / 4]);
      @(negedge clk);
    end
  endtask

  initial begin
    keys  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_columnas", columnas, 4'b1110);
    check_eq("rst_tecla", tecla, 0);
    check_eq("rst_valida", tecla_valida, 0);
    check_eq("rst_presionada", tecla_presionada, 0);
    check_eq("rst_liberada", tecla_liberada, 0);
    check_eq("rst_multi", multi_tecla, 0);
    rst_n = 1'b1;
    check_sweep("sweep");

    // Clean press of row 1 / column 2 -> code 6.
    base_v = valida_hi;
    keys[1][2] = 1'b1;
    run_frames(2);
    check_eq("press_f2_valida", tecla_valida, 0);
    check_eq("press_f2_presionada", tecla_presionada, 0);
    run_frames(1);
    check_eq("press_f3_valida", tecla_valida, 1);
    check_eq("press_f3_tecla", tecla, 6);
    check_eq("press_f3_presionada", tecla_presionada, 1);
    run_frames(3);
    check_eq("press_strobe_count", valida_hi - base_v, 1);

    // Short release (2 frames) then touch again: no release event.
    base_l = liberada_hi;
    keys = '0;
    run_frames(2);
    check_eq("rel2_presionada", tecla_presionada, 1);
    check_eq("rel2_liberada", tecla_liberada, 0);
    keys[1][2] = 1'b1;
    run_frames(1);
    check_eq("retouch_presionada", tecla_presionada, 1);
    keys = '0;
    run_frames(2);
    check_eq("rel_f2_liberada", tecla_liberada, 0);
    run_frames(1);
    check_eq("rel_f3_liberada", tecla_liberada, 1);
    check_eq("rel_f3_presionada", tecla_presionada, 0);
    check_eq("rel_f3_tecla", tecla, 6);
    run_frames(1);
    check_eq("rel_strobe_count", liberada_hi - base_l, 1);
    check_eq("rel_no_extra_valida", valida_hi - base_v, 1);

    // Bounce on code 13: 2 on, 1 off, 2 on, then off.
    base_v = valida_hi;
    keys[3][1] = 1'b1; run_frames(2);
    keys = '0;         run_frames(1);
    keys[3][1] = 1'b1; run_frames(2);
    keys = '0;         run_frames(2);
    check_eq("bounce_valida_count", valida_hi - base_v, 0);
    check_eq("bounce_presionada", tecla_presionada, 0);
    check_eq("bounce_tecla", tecla, 6);

    // Ghost: (0,0) + (2,3) together, then only (2,3) -> code 11.
    base_v = valida_hi;
    keys[0][0] = 1'b1; keys[2][3] = 1'b1;
    run_frames(1);
    check_eq("ghost_multi", multi_tecla, 1);
    run_frames(2);
    check_eq("ghost_valida_count", valida_hi - base_v, 0);
    check_eq("ghost_presionada", tecla_presionada, 0);
    keys[0][0] = 1'b0;
    run_frames(2);
    check_eq("ghost_multi_clear", multi_tecla, 0);
    check_eq("ghost_f2_valida", tecla_valida, 0);
    run_frames(1);
    check_eq("ghost_accept_valida", tecla_valida, 1);
    check_eq("ghost_accept_tecla", tecla, 11);
    keys = '0;
    run_frames(4);

    // Long hold of code 9 (row 2 / column 1).
    base_v = valida_hi;
    keys[2][1] = 1'b1;
    run_frames(3);
    check_eq("hold_accept_tecla", tecla, 9);
    run_frames(5);
`ifdef TECLADO_REPEAT_EN
    check_eq("hold_repeat_f5", valida_hi - base_v, 2);
    exp_rep = 5;
`else
    check_eq("hold_norepeat_f5", valida_hi - base_v, 1);
    exp_rep = 1;
`endif
    run_frames(7);
    check_eq("hold_valida_count", valida_hi - base_v, exp_rep);
    check_eq("hold_tecla_stable", tecla, 9);
    keys = '0;
    run_frames(4);

    // Reset in the middle of a debounce.
    base_v = valida_hi;
    keys[0][1] = 1'b1;
    run_frames(2);
    #3 rst_n = 1'b0;
    #1;
    check_eq("midrst_columnas", columnas, 4'b1110);
    check_eq("midrst_tecla", tecla, 0);
    check_eq("midrst_presionada", tecla_presionada, 0);
    check_eq("midrst_valida", tecla_valida, 0);
    check_eq("midrst_multi", multi_tecla, 0);
    keys = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check_sweep("midrst_sweep");
    run_frames(3);
    check_eq("midrst_no_strobe", valida_hi - base_v, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
